// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - register file access bus: write port, dual read ports, clear sweep
//
// Purpose: bundles the write, read and clear controls and the read data/busy
//          returns of reg_file_param into one interface.
// Ports (signals):
//   WRITE, ADDR_W, DATA_W      write enable, address, data
//   READ, ADDR_R1, ADDR_R2     shared read enable, per-port read addresses
//   CLEAR                      request a zero-sweep of all registers
//   DATA_R1, DATA_R2           registered read data
//   BUSY                       high while a clear sweep is running
// Modports: master drives requests, slave is the register file.

interface reg_file_param_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             WRITE;
    logic [AW-1:0]    ADDR_W;
    logic [WIDTH-1:0] DATA_W;
    logic             READ;
    logic [AW-1:0]    ADDR_R1;
    logic [AW-1:0]    ADDR_R2;
    logic             CLEAR;
    logic [WIDTH-1:0] DATA_R1;
    logic [WIDTH-1:0] DATA_R2;
    logic             BUSY;

    modport master (
        output WRITE, ADDR_W, DATA_W, READ, ADDR_R1, ADDR_R2, CLEAR,
        input  DATA_R1, DATA_R2, BUSY
    );

    modport slave (
        input  WRITE, ADDR_W, DATA_W, READ, ADDR_R1, ADDR_R2, CLEAR,
        output DATA_R1, DATA_R2, BUSY
    );
endinterface

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised 1W/2R register file with sequential clear sweep
//
// Purpose: DEPTH = 2**AW registers of WIDTH bits. One write port, two read
//          ports sharing one read enable with one cycle of latency, optional
//          hard-wired zero register 0, optional write-to-read forwarding, and a
//          CLEAR-triggered sweep that zeroes one register per cycle.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset (clears registers, outputs, sweep)
//   bus    reg_file_param_if.slave: write/read/clear requests, read data, BUSY

module reg_file_param #(
    parameter int WIDTH   = 32,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input logic             CLK,
    input logic             RESET,
    reg_file_param_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] data_r1;
    logic [WIDTH-1:0] data_r2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy;
    logic             wr_en;

    assign busy        = (state == SWEEP);
    assign bus.BUSY    = busy;
    assign bus.DATA_R1 = data_r1;
    assign bus.DATA_R2 = data_r2;

    // A write is accepted only outside a sweep; register 0 drops writes when
    // it is hard-wired to zero.
    assign wr_en = bus.WRITE && !busy && !(ZERO_R0 && (bus.ADDR_W == '0));

    // Value a read port captures at this edge. Forwarding covers both a write
    // landing on the same address and the sweep zeroing the same address, so
    // with BYPASS the read sees the post-edge contents.
    function automatic logic [WIDTH-1:0] rd_val(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = mem[a];
        if (BYPASS && wr_en && (a == bus.ADDR_W)) begin
            v = bus.DATA_W;
        end
        if (BYPASS && busy && (a == idx)) begin
            v = '0;
        end
        if (ZERO_R0 && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd1 = rd_val(bus.ADDR_R1);
        rd2 = rd_val(bus.ADDR_R2);
    end

    // Sweep FSM next-state logic. CLEAR is only sampled in IDLE, so a held
    // CLEAR restarts on the first edge after the sweep ends.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (bus.CLEAR) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next   = idx + AW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            idx     <= '0;
            data_r1 <= '0;
            data_r2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (bus.READ) begin
                data_r1 <= rd1;
                data_r2 <= rd2;
            end
            // wr_en already excludes the sweep, so the two never collide.
            if (busy) begin
                mem[idx] <= '0;
            end else if (wr_en) begin
                mem[bus.ADDR_W] <= bus.DATA_W;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param in two configurations

module tb_reg_file_param;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    reg_file_param_if #(.WIDTH(32), .AW(5)) bus0();
    reg_file_param_if #(.WIDTH(8),  .AW(3)) bus1();

    reg_file_param #(.WIDTH(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0)
    );
    reg_file_param #(.WIDTH(8), .AW(3), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    // Reference model: index 0 = 32-bit/32-deep/R0 zero/no bypass,
    // index 1 = 8-bit/8-deep/R0 normal/bypass.
    int          dep   [2] = '{32, 8};
    bit          byp   [2] = '{1'b0, 1'b1};
    bit          zr    [2] = '{1'b1, 1'b0};
    logic [31:0] dmask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] mm    [2][32];
    bit          mbusy [2];
    int          sidx  [2];
    logic [31:0] o1    [2];
    logic [31:0] o2    [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mm[k][i] = '0;
            mbusy[k] = 1'b0;
            sidx[k]  = 0;
            o1[k]    = '0;
            o2[k]    = '0;
        end
    endtask

    function automatic logic [31:0] rv(input int k, input int a, input bit wr,
                                       input int aw, input logic [31:0] dw);
        if (zr[k] && a == 0) return '0;
        if (byp[k] && wr && a == aw) return dw;
        if (byp[k] && mbusy[k] && a == sidx[k]) return '0;
        return mm[k][a];
    endfunction

    task automatic model_step(input int k, input bit w, input int aw_i, input logic [31:0] dw_i,
                              input bit r, input int a1_i, input int a2_i, input bit clr);
        int          aw;
        int          a1;
        int          a2;
        logic [31:0] dw;
        bit          wr;
        aw = aw_i % dep[k];
        a1 = a1_i % dep[k];
        a2 = a2_i % dep[k];
        dw = dw_i & dmask[k];
        wr = w && !mbusy[k] && !(zr[k] && aw == 0);
        if (r) begin
            o1[k] = rv(k, a1, wr, aw, dw);
            o2[k] = rv(k, a2, wr, aw, dw);
        end
        if (mbusy[k]) begin
            mm[k][sidx[k]] = '0;
            sidx[k]++;
            if (sidx[k] == dep[k]) begin
                mbusy[k] = 1'b0;
                sidx[k]  = 0;
            end
        end else if (clr) begin
            mbusy[k] = 1'b1;
            sidx[k]  = 0;
        end
        if (wr) mm[k][aw] = dw;
    endtask

    // Called at negedge+1; applies one edge of stimulus and queues expectations.
    task automatic cyc(input bit w, input int aw, input logic [31:0] dw,
                       input bit r, input int a1, input int a2, input bit clr);
        exp_t e;
        bus0.WRITE = w;   bus0.ADDR_W = 5'(aw);  bus0.DATA_W = dw;
        bus0.READ  = r;   bus0.ADDR_R1 = 5'(a1); bus0.ADDR_R2 = 5'(a2);
        bus0.CLEAR = clr;
        bus1.WRITE = w;   bus1.ADDR_W = 3'(aw);  bus1.DATA_W = dw[7:0];
        bus1.READ  = r;   bus1.ADDR_R1 = 3'(a1); bus1.ADDR_R2 = 3'(a2);
        bus1.CLEAR = clr;
        for (int k = 0; k < 2; k++) model_step(k, w, aw, dw, r, a1, a2, clr);
        e.d1 = o1[0]; e.d2 = o2[0]; e.busy = mbusy[0]; q0.push_back(e);
        e.d1 = o1[1]; e.d2 = o2[1]; e.busy = mbusy[1]; q1.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    // Monitor: one expectation per edge per DUT, compared on the falling edge.
    always @(negedge CLK) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("d0_r1", bus0.DATA_R1, e0.d1);
            chk("d0_r2", bus0.DATA_R2, e0.d2);
            chk("d0_busy", {31'b0, bus0.BUSY}, {31'b0, e0.busy});
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("d1_r1", {24'b0, bus1.DATA_R1}, e1.d1);
            chk("d1_r2", {24'b0, bus1.DATA_R2}, e1.d2);
            chk("d1_busy", {31'b0, bus1.BUSY}, {31'b0, e1.busy});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        int n1;
        RESET = 1'b0;
        bus0.WRITE = 0; bus0.ADDR_W = '0; bus0.DATA_W = '0; bus0.READ = 0;
        bus0.ADDR_R1 = '0; bus0.ADDR_R2 = '0; bus0.CLEAR = 0;
        bus1.WRITE = 0; bus1.ADDR_W = '0; bus1.DATA_W = '0; bus1.READ = 0;
        bus1.ADDR_R1 = '0; bus1.ADDR_R2 = '0; bus1.CLEAR = 0;
        model_reset();
        #2;
        chk("rst_d0_r1", bus0.DATA_R1, 32'h0);
        chk("rst_d0_r2", bus0.DATA_R2, 32'h0);
        chk("rst_d0_busy", {31'b0, bus0.BUSY}, 32'h0);
        chk("rst_d1_r1", {24'b0, bus1.DATA_R1}, 32'h0);
        @(negedge CLK);
        #1;
        RESET = 1'b1;

        // Dual-port read of the same address
        cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 5, 0);
        chk("rd5_p1", bus0.DATA_R1, 32'hDEAD_BEEF);
        chk("rd5_p2", bus0.DATA_R2, 32'hDEAD_BEEF);
        chk("rd5_small", {24'b0, bus1.DATA_R1}, 32'hEF);

        // Register 0 hard-wired zero vs. normal register 0
        cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("r0_zero", bus0.DATA_R1, 32'h0);
        chk("r0_normal", {24'b0, bus1.DATA_R1}, 32'hFF);

        // Read/write collision, with and without forwarding
        cyc(1, 7, 32'h11, 0, 0, 0, 0);
        cyc(1, 7, 32'h22, 1, 7, 7, 0);
        chk("coll_nobyp", bus0.DATA_R1, 32'h11);
        chk("coll_byp", {24'b0, bus1.DATA_R2}, 32'h22);
        cyc(0, 0, 0, 1, 7, 7, 0);
        chk("coll_after", bus0.DATA_R1, 32'h22);

        cyc(1, 7, 32'h5A, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 7, 0, 0);
        chk("small_5a", {24'b0, bus1.DATA_R1}, 32'h5A);

        // Fill, clear sweep, lost write, sweep length
        for (int i = 0; i < 32; i++) cyc(1, i, $urandom, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus0.BUSY && !bus1.BUSY) break;
            n0 += int'(bus0.BUSY);
            n1 += int'(bus1.BUSY);
            cyc(i == 5, 3, 32'hAA, 1, i % 32, $urandom_range(0, 31), 0);
        end
        chk("busy_len32", n0, 32);
        chk("busy_len8", n1, 8);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 1, i, 31 - i, 0);
        cyc(0, 0, 0, 1, 3, 3, 0);
        chk("lost_write3", bus0.DATA_R1, 32'h0);

        // CLEAR held high across sweeps
        for (int i = 0; i < 40; i++) cyc(i % 3 == 0, i, $urandom, 1, $urandom_range(0, 31), i, 1);
        for (int i = 0; i < 40; i++) cyc(1, i, $urandom, 1, i, $urandom_range(0, 31), 0);

        // Asynchronous reset mid-sweep (IDX=10 on the 32-deep file)
        for (int i = 0; i < 32; i++) cyc(1, i, $urandom | 32'h1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, i, i + 11, 0);
        RESET = 1'b0;
        #1;
        chk("arst_r1", bus0.DATA_R1, 32'h0);
        chk("arst_r2", bus0.DATA_R2, 32'h0);
        chk("arst_busy", {31'b0, bus0.BUSY}, 32'h0);
        model_reset();
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 1, i, 31 - i, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int aw;
            aw = $urandom_range(0, 31);
            cyc($urandom_range(0, 1) == 1, aw, $urandom, $urandom_range(0, 9) < 7,
                ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, 31),
                ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, 31),
                $urandom_range(0, 49) == 0);
        end

        chk("queues_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
